gb_lcd_timing_gen: RTL and testbench

Generates Game Boy LCD-side video signals (VSYNC, HSYNC, PIXEL_CLK, 2-bit DATA) from the 16 MHz board clock. It produces the same interface the capture path and the frame counter consume, so it serves as the on-board stimulus source for bring-up and as a loopback test source. Dot rate is 4.194304 MHz, derived with a fractional accumulator. Frame rate is about 59.73 Hz, with 456 dots x 154 lines per frame.

---
 rtl/gb_lcd_pkg.sv | 44 ++++
 rtl/gb_lcd_timing_gen_tick.sv | 35 +++
 rtl/gb_lcd_timing_gen.sv | 102 ++++++++++
 tb/tb_gb_lcd_timing_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_lcd_pkg.sv
// Shared geometry, accumulator constants and pattern codes for the Game Boy
// LCD timing generator.
package gb_lcd_pkg;

  localparam int DOTS_PER_LINE   = 456;
  localparam int LINES_PER_FRAME = 154;
  localparam int ACTIVE_W        = 160;
  localparam int ACTIVE_H        = 144;
  localparam int HSYNC_START     = 160;
  localparam int HSYNC_LEN       = 8;

  // 16384 / 62500 of 16 MHz gives the 4.194304 MHz dot rate
  localparam int ACC_INC = 16384;
  localparam int ACC_MOD = 62500;

  localparam int ACC_W  = 17;
  localparam int DOT_W  = 9;
  localparam int LINE_W = 8;

  typedef enum logic [1:0] {
    PAT_SOLID  = 2'd0,
    PAT_BARS   = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_SCROLL = 2'd3
  } pattern_t;

  function automatic logic [1:0] pattern_pixel(
    input pattern_t   pat,
    input logic [1:0] x_bar,
    input logic       x3,
    input logic       y3,
    input logic [1:0] frame_lsb
  );
    logic [1:0] pix;
    case (pat)
      PAT_SOLID: pix = 2'd3;
      PAT_BARS:  pix = x_bar;
      PAT_CHECK: pix = {2{x3 ^ y3}};
      default:   pix = x_bar + frame_lsb;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/gb_lcd_timing_gen_tick.sv
// Fractional accumulator producing one-cycle dot ticks at ACC_INC/ACC_MOD of
// the board clock; spacing is always 3 or 4 clocks at the default ratio.
module gb_dot_tick_gen #(
  parameter int ACC_INC = gb_lcd_pkg::ACC_INC,
  parameter int ACC_MOD = gb_lcd_pkg::ACC_MOD
) (
  input  logic CLK16MHz,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);
  import gb_lcd_pkg::*;

  localparam logic [ACC_W-1:0] INC = ACC_W'(ACC_INC);
  localparam logic [ACC_W-1:0] MOD = ACC_W'(ACC_MOD);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + INC;

  always_ff @(posedge CLK16MHz) begin
    if (RESET || !ENABLE) begin
      acc  <= '0;
      TICK <= 1'b0;
    end else if (acc_sum >= MOD) begin
      acc  <= acc_sum - MOD;
      TICK <= 1'b1;
    end else begin
      acc  <= acc_sum;
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/gb_lcd_timing_gen.sv
// Game Boy LCD-side video source: dot/line counters, sync decode and test
// patterns, clocked by the fractional dot tick.
module gb_lcd_timing_gen #(
  parameter int DOTS_PER_LINE   = gb_lcd_pkg::DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = gb_lcd_pkg::LINES_PER_FRAME,
  parameter int ACTIVE_W        = gb_lcd_pkg::ACTIVE_W,
  parameter int ACTIVE_H        = gb_lcd_pkg::ACTIVE_H,
  parameter int HSYNC_START     = gb_lcd_pkg::HSYNC_START,
  parameter int HSYNC_LEN       = gb_lcd_pkg::HSYNC_LEN,
  parameter int ACC_INC         = gb_lcd_pkg::ACC_INC,
  parameter int ACC_MOD         = gb_lcd_pkg::ACC_MOD
) (
  input  logic       CLK16MHz,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN,
  output logic       PIXEL_CLK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [1:0] DATA,
  output logic [7:0] FRAME_NUM
);
  import gb_lcd_pkg::*;

  localparam logic [DOT_W-1:0]  DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [DOT_W-1:0]  ACT_X     = DOT_W'(ACTIVE_W);
  localparam logic [LINE_W-1:0] ACT_Y     = LINE_W'(ACTIVE_H);
  localparam logic [DOT_W-1:0]  HS_FIRST  = DOT_W'(HSYNC_START);
  localparam logic [DOT_W-1:0]  HS_END    = DOT_W'(HSYNC_START + HSYNC_LEN);

  logic              tick;
  logic [DOT_W-1:0]  dot;
  logic [LINE_W-1:0] line;
  pattern_t          pat_q;
  pattern_t          pat_cur;
  logic              pclk_cnt;
  logic              active;
  logic              frame_start;

  gb_dot_tick_gen #(
    .ACC_INC (ACC_INC),
    .ACC_MOD (ACC_MOD)
  ) u_tick (
    .CLK16MHz (CLK16MHz),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .TICK     (tick)
  );

  // The counters name the dot being emitted on this tick; PATTERN is only
  // taken on the first dot of a frame so a frame never mixes patterns.
  assign frame_start = (dot == '0) && (line == '0);
  assign pat_cur     = frame_start ? pattern_t'(PATTERN) : pat_q;
  assign active      = (dot < ACT_X) && (line < ACT_Y);

  always_ff @(posedge CLK16MHz) begin
    if (RESET || !ENABLE) begin
      dot       <= '0;
      line      <= '0;
      pclk_cnt  <= 1'b0;
      PIXEL_CLK <= 1'b0;
      HSYNC     <= 1'b0;
      VSYNC     <= 1'b0;
      DATA      <= 2'd0;
      if (RESET) begin
        FRAME_NUM <= 8'd0;
        pat_q     <= PAT_SOLID;
      end
    end else begin
      if (tick) begin
        HSYNC <= (dot >= HS_FIRST) && (dot < HS_END);
        VSYNC <= (line == '0);
        pat_q <= pat_cur;
        DATA  <= active ? pattern_pixel(pat_cur, dot[5:4], dot[3], line[3], FRAME_NUM[1:0])
                        : 2'd0;
        if (dot == DOT_LAST) begin
          dot <= '0;
          if (line == LINE_LAST) begin
            line      <= '0;
            FRAME_NUM <= FRAME_NUM + 8'd1;
          end else begin
            line <= line + 1'b1;
          end
        end else begin
          dot <= dot + 1'b1;
        end
      end

      // Two-clock strobe: set on the active tick, held one more clock by the down-count
      if (tick && active) begin
        PIXEL_CLK <= 1'b1;
        pclk_cnt  <= 1'b1;
      end else if (pclk_cnt) begin
        pclk_cnt <= 1'b0;
      end else begin
        PIXEL_CLK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gb_lcd_timing_gen.sv
// Directed bench for gb_lcd_timing_gen, run on a shrunken frame (80x12 dots,
// 64x10 active) so whole frames fit in a short run; tick ratio is the default.
`timescale 1ns/1ps
module tb_gb_lcd_timing_gen;

  localparam int T_DOTS  = 80;
  localparam int T_LINES = 12;
  localparam int T_AW    = 64;
  localparam int T_AH    = 10;
  localparam int T_HS    = 64;
  localparam int T_HL    = 8;

  logic       CLK16MHz = 1'b0;
  logic       RESET    = 1'b1;
  logic       ENABLE   = 1'b0;
  logic [1:0] PATTERN  = 2'd0;
  logic       PIXEL_CLK;
  logic       HSYNC;
  logic       VSYNC;
  logic [1:0] DATA;
  logic [7:0] FRAME_NUM;

  int total = 0;
  int bad   = 0;

  gb_lcd_timing_gen #(
    .DOTS_PER_LINE   (T_DOTS),
    .LINES_PER_FRAME (T_LINES),
    .ACTIVE_W        (T_AW),
    .ACTIVE_H        (T_AH),
    .HSYNC_START     (T_HS),
    .HSYNC_LEN       (T_HL)
  ) dut (
    .CLK16MHz  (CLK16MHz),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .PATTERN   (PATTERN),
    .PIXEL_CLK (PIXEL_CLK),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .DATA      (DATA),
    .FRAME_NUM (FRAME_NUM)
  );

  always #31.25 CLK16MHz = ~CLK16MHz;

  task automatic step();
    @(posedge CLK16MHz);
    #1;
  endtask

  task automatic apply_reset(input int n);
    RESET = 1'b1;
    repeat (n) step();
    RESET = 1'b0;
  endtask

  task automatic wait_vs_rise(input int budget, output int cyc, output bit ok);
    logic prev;
    prev = VSYNC;
    ok   = 1'b0;
    cyc  = 0;
    while (!ok && cyc < budget) begin
      step();
      cyc++;
      if (VSYNC && !prev) ok = 1'b1;
      prev = VSYNC;
    end
  endtask

  task automatic test_reset();
    int first_tick;
    int vs_at;
    logic pc_at_vs;
    logic [1:0] data_at_vs;
    ENABLE  = 1'b1;
    PATTERN = 2'd0;
    RESET   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({PIXEL_CLK, HSYNC, VSYNC, DATA, FRAME_NUM} !== 13'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=0", i, {PIXEL_CLK, HSYNC, VSYNC, DATA, FRAME_NUM});
      end
    end
    RESET = 1'b0;
    first_tick = 0;
    vs_at      = 0;
    pc_at_vs   = 1'b0;
    data_at_vs = 2'd0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (dut.tick && first_tick == 0) first_tick = c;
      if (VSYNC && vs_at == 0) begin
        vs_at      = c;
        pc_at_vs   = PIXEL_CLK;
        data_at_vs = DATA;
      end
    end
    total++;
    if (first_tick < 1 || first_tick > 4) begin
      bad++;
      $display("FAIL first_tick got=%0d want=1..4", first_tick);
    end
    total++;
    if (vs_at !== first_tick + 1) begin
      bad++;
      $display("FAIL vsync_after_tick got=%0d want=%0d", vs_at, first_tick + 1);
    end
    total++;
    if (pc_at_vs !== 1'b1 || data_at_vs !== 2'd3) begin
      bad++;
      $display("FAIL first_pixel pclk=%b data=%0d want pclk=1 data=3", pc_at_vs, data_at_vs);
    end
  endtask

  task automatic test_tick_rate();
    int n;
    int last;
    int gap;
    ENABLE = 1'b1;
    apply_reset(3);
    n    = 0;
    last = 0;
    // 15625 clocks is exactly 4096 ticks (16384/62500 reduced)
    for (int i = 1; i <= 15625; i++) begin
      step();
      if (dut.tick) begin
        n++;
        if (last > 0) begin
          gap = i - last;
          total++;
          if (gap < 3 || gap > 4) begin
            bad++;
            $display("FAIL tick_gap at=%0d got=%0d want=3..4", i, gap);
          end
        end
        last = i;
      end
    end
    total++;
    if (n != 4096) begin
      bad++;
      $display("FAIL tick_count got=%0d want=4096", n);
    end
  endtask

  task automatic test_full_frame();
    int cyc;
    bit ok;
    bit done;
    int pc_w, pc_n, pc_badw, hs_w, hs_n, hs_badw, vs_w, vs_n, vs_len, data_bad;
    logic pc_p, hs_p, vs_p;
    ENABLE  = 1'b1;
    PATTERN = 2'd0;
    apply_reset(3);
    wait_vs_rise(20, cyc, ok);
    total++;
    if (!ok || FRAME_NUM !== 8'd0) begin
      bad++;
      $display("FAIL frame_start ok=%0d frame_num=%0d want ok=1 frame_num=0", ok, FRAME_NUM);
    end
    pc_w = PIXEL_CLK ? 1 : 0; hs_w = 0; vs_w = 1;
    pc_n = 0; pc_badw = 0; hs_n = 0; hs_badw = 0; vs_n = 0; vs_len = 0;
    data_bad = (PIXEL_CLK && DATA !== 2'd3) ? 1 : 0;
    pc_p = PIXEL_CLK; hs_p = HSYNC; vs_p = VSYNC;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      step();
      if (VSYNC && !vs_p) begin
        done = 1'b1;
      end else begin
        if (PIXEL_CLK) pc_w++;
        else if (pc_p) begin pc_n++; if (pc_w != 2) pc_badw++; pc_w = 0; end
        if (PIXEL_CLK && DATA !== 2'd3) data_bad++;
        if (HSYNC) hs_w++;
        else if (hs_p) begin hs_n++; if (hs_w < 30 || hs_w > 31) hs_badw++; hs_w = 0; end
        if (VSYNC) vs_w++;
        else if (vs_p) begin vs_n++; vs_len = vs_w; vs_w = 0; end
      end
      pc_p = PIXEL_CLK; hs_p = HSYNC; vs_p = VSYNC;
    end
    total++;
    if (!done) begin bad++; $display("FAIL frame_end_timeout got=none want=vsync_rise"); end
    total++;
    if (pc_n != T_AW * T_AH) begin bad++; $display("FAIL pclk_pulses got=%0d want=%0d", pc_n, T_AW * T_AH); end
    total++;
    if (pc_badw != 0) begin bad++; $display("FAIL pclk_width bad_pulses=%0d want=0", pc_badw); end
    total++;
    if (data_bad != 0) begin bad++; $display("FAIL solid_data bad_pixels=%0d want=0", data_bad); end
    total++;
    if (hs_n != T_LINES) begin bad++; $display("FAIL hsync_pulses got=%0d want=%0d", hs_n, T_LINES); end
    total++;
    if (hs_badw != 0) begin bad++; $display("FAIL hsync_width bad_pulses=%0d want=0", hs_badw); end
    total++;
    if (vs_n != 1 || vs_len < 305 || vs_len > 306) begin
      bad++;
      $display("FAIL vsync_pulse count=%0d len=%0d want count=1 len=305..306", vs_n, vs_len);
    end
    total++;
    if (FRAME_NUM !== 8'd1) begin bad++; $display("FAIL frame_num_after_frame got=%0d want=1", FRAME_NUM); end
  endtask

  task automatic test_patterns();
    int cyc;
    bit ok;
    int f;
    int idx;
    logic pc_p, vs_p;
    logic [7:0] xv, yv;
    logic [1:0] expd;
    ENABLE  = 1'b1;
    PATTERN = 2'd1;
    apply_reset(3);
    wait_vs_rise(20, cyc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pattern_start_timeout got=none want=vsync_rise"); end
    f = 0; idx = 0; pc_p = 1'b0; vs_p = 1'b0;
    for (int c = 0; c < 13000 && f < 3; c++) begin
      if (VSYNC && !vs_p && c > 0) begin
        f++;
        idx = 0;
        if (f < 3) begin
          total++;
          if (FRAME_NUM !== 8'(f)) begin bad++; $display("FAIL pattern_frame_num got=%0d want=%0d", FRAME_NUM, f); end
        end
      end
      if (f < 3 && PIXEL_CLK && !pc_p) begin
        xv = 8'(idx % T_AW);
        yv = 8'(idx / T_AW);
        case (f)
          0:       expd = xv[5:4];
          1:       expd = (xv[3] ^ yv[3]) ? 2'd3 : 2'd0;
          default: expd = xv[5:4] + 2'd2;
        endcase
        total++;
        if (DATA !== expd) begin
          bad++;
          $display("FAIL pattern_pixel frame=%0d x=%0d y=%0d got=%0d want=%0d", f, xv, yv, DATA, expd);
        end
        idx++;
        if (idx == 3 * T_AW && f < 2) PATTERN = (f == 0) ? 2'd2 : 2'd3;
      end
      pc_p = PIXEL_CLK;
      vs_p = VSYNC;
      step();
    end
    total++;
    if (f < 3) begin bad++; $display("FAIL pattern_frames got=%0d want=3", f); end
  endtask

  task automatic test_enable_drop();
    int cyc;
    bit ok;
    bit found;
    int idx;
    int vs_at;
    int zero_bad;
    logic pc_p;
    ENABLE  = 1'b1;
    PATTERN = 2'd0;
    apply_reset(3);
    wait_vs_rise(20, cyc, ok);
    wait_vs_rise(5000, cyc, ok);
    total++;
    if (!ok || FRAME_NUM !== 8'd1) begin
      bad++;
      $display("FAIL drop_setup ok=%0d frame_num=%0d want ok=1 frame_num=1", ok, FRAME_NUM);
    end
    idx = 0; pc_p = 1'b0; found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      if (PIXEL_CLK && !pc_p) begin
        if (idx == 5 * T_AW + 30) found = 1'b1;
        idx++;
      end
      pc_p = PIXEL_CLK;
      if (!found) step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL drop_point_timeout got=none want=line5_dot30"); end
    ENABLE = 1'b0;
    step();
    total++;
    if ({PIXEL_CLK, HSYNC, VSYNC, DATA} !== 5'd0 || FRAME_NUM !== 8'd1) begin
      bad++;
      $display("FAIL drop_outputs got=%b frame_num=%0d want=0 frame_num=1", {PIXEL_CLK, HSYNC, VSYNC, DATA}, FRAME_NUM);
    end
    zero_bad = 0;
    repeat (20) begin
      step();
      if ({PIXEL_CLK, HSYNC, VSYNC, DATA} !== 5'd0 || FRAME_NUM !== 8'd1) zero_bad++;
    end
    total++;
    if (zero_bad != 0) begin bad++; $display("FAIL disabled_hold bad_cycles=%0d want=0", zero_bad); end
    ENABLE = 1'b1;
    vs_at  = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (VSYNC && vs_at == 0) vs_at = c;
    end
    total++;
    if (vs_at < 1 || vs_at > 5) begin bad++; $display("FAIL reenable_vsync got=%0d want=1..5", vs_at); end
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      step();
      if (!VSYNC) found = 1'b1;
    end
    total++;
    if (!found || FRAME_NUM !== 8'd1) begin
      bad++;
      $display("FAIL aborted_frame_num found=%0d got=%0d want=1", found, FRAME_NUM);
    end
    wait_vs_rise(5000, cyc, ok);
    total++;
    if (!ok || FRAME_NUM !== 8'd2) begin
      bad++;
      $display("FAIL complete_frame_num ok=%0d got=%0d want=2", ok, FRAME_NUM);
    end
  endtask

  task automatic test_abort_with_syncs();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (VSYNC && HSYNC) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL sync_window_timeout got=none want=vsync_and_hsync"); end
    ENABLE = 1'b0;
    step();
    total++;
    if ({PIXEL_CLK, HSYNC, VSYNC, DATA} !== 5'd0 || FRAME_NUM !== 8'd2) begin
      bad++;
      $display("FAIL drop_in_sync got=%b frame_num=%0d want=0 frame_num=2", {PIXEL_CLK, HSYNC, VSYNC, DATA}, FRAME_NUM);
    end
    ENABLE = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (VSYNC && HSYNC) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL sync_window2_timeout got=none want=vsync_and_hsync"); end
    RESET = 1'b1;
    step();
    total++;
    if ({PIXEL_CLK, HSYNC, VSYNC, DATA, FRAME_NUM} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_frame got=%b want=0", {PIXEL_CLK, HSYNC, VSYNC, DATA, FRAME_NUM});
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_full_frame();
    test_patterns();
    test_enable_drop();
    test_abort_with_syncs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
